// File: rtl/gtfmac_cfg_pkg.sv
// Shared types and constants for the GTFMAC config sequencer.
// Register offsets, error codes, FSM states and the table helpers.
package gtfmac_cfg_pkg;

    localparam logic [31:0] MAC_CFG8  = 32'h0000_0000;
    localparam logic [31:0] MAC_CFG9  = 32'h0000_0004;
    localparam logic [31:0] MAC_CFG10 = 32'h0000_0008;
    localparam logic [31:0] MAC_CFG11 = 32'h0000_000C;
    localparam logic [31:0] MAC_CFG12 = 32'h0000_0010;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_RESP     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_MISMATCH = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD,
        ST_RD_DATA,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef struct packed {
        logic        rx_rate;
        logic        tx_rate;
        logic        fcs_ins;
        logic        tx_ignore;
        logic        rx_ignore;
        logic [7:0]  min_len;
        logic [15:0] max_len;
    } cfg_t;

    function automatic logic [31:0] reg_offset(input logic [2:0] k);
        case (k)
            3'd0:    return MAC_CFG8;
            3'd1:    return MAC_CFG9;
            3'd2:    return MAC_CFG10;
            3'd3:    return MAC_CFG11;
            3'd4:    return MAC_CFG12;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] field_mask(input logic [2:0] k);
        case (k)
            3'd0:    return 32'h0000_0003;
            3'd1:    return 32'h0000_0006;
            3'd2:    return 32'h0000_0004;
            3'd3:    return 32'h0000_00FF;
            3'd4:    return 32'h0000_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] table_word(
        input logic [2:0] k,
        input cfg_t       c
    );
        case (k)
            3'd0:    return {30'b0, c.tx_rate, c.rx_rate};
            3'd1:    return {29'b0, c.tx_ignore, c.fcs_ins, 1'b0};
            3'd2:    return {29'b0, c.rx_ignore, 2'b0};
            3'd3:    return {24'b0, c.min_len};
            3'd4:    return {16'b0, c.max_len};
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/gtfmac_cfg_sequencer_xact.sv
// gtfmac_axil_single_xact: drives one AXI-Lite phase per FSM state with a timeout.
// Ports: state/clr from the sequencer, addr/wdata in; ok/resp_err/timeout/rdata out; AXI master.
module gtfmac_axil_single_xact
    import gtfmac_cfg_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        S0_s_axi_aclk,
    input  logic        S0_s_axi_aresetn,
    input  state_t      state,
    input  logic        clr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ok,
    output logic        resp_err,
    output logic        timeout,
    output logic [31:0] rdata,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    logic        in_wr, in_wresp, in_rd, in_rdata, active;
    logic        aw_done, w_done, aw_hs, w_hs;
    logic [15:0] cnt;

    assign in_wr    = (state == ST_WR);
    assign in_wresp = (state == ST_WR_RESP);
    assign in_rd    = (state == ST_RD);
    assign in_rdata = (state == ST_RD_DATA);
    assign active   = in_wr | in_wresp | in_rd | in_rdata;

    // Valids decode from registered state, so they drop
    // together with an asynchronous reset of the FSM.
    assign m_axi_awvalid = in_wr & ~aw_done;
    assign m_axi_wvalid  = in_wr & ~w_done;
    assign m_axi_awaddr  = in_wr ? addr : 32'h0;
    assign m_axi_wdata   = in_wr ? wdata : 32'h0;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_bready  = in_wresp;
    assign m_axi_arvalid = in_rd;
    assign m_axi_araddr  = in_rd ? addr : 32'h0;
    assign m_axi_rready  = in_rdata;
    assign rdata         = m_axi_rdata;

    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid & m_axi_wready;

    always_ff @(posedge S0_s_axi_aclk or negedge S0_s_axi_aresetn) begin
        if (!S0_s_axi_aresetn) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (!in_wr) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            aw_done <= aw_done | aw_hs;
            w_done  <= w_done | w_hs;
        end
    end

    always_ff @(posedge S0_s_axi_aclk or negedge S0_s_axi_aresetn) begin
        if (!S0_s_axi_aresetn)
            cnt <= 16'h0;
        else if (clr)
            cnt <= 16'h0;
        else if (active)
            cnt <= cnt + 16'h1;
    end

    always_comb begin
        ok       = 1'b0;
        resp_err = 1'b0;
        unique case (1'b1)
            in_wr: ok = (aw_done | aw_hs) & (w_done | w_hs);
            in_wresp: begin
                ok       = m_axi_bvalid & (m_axi_bresp == 2'b00);
                resp_err = m_axi_bvalid & (m_axi_bresp != 2'b00);
            end
            in_rd: ok = m_axi_arready;
            in_rdata: begin
                ok       = m_axi_rvalid & (m_axi_rresp == 2'b00);
                resp_err = m_axi_rvalid & (m_axi_rresp != 2'b00);
            end
            default: ;
        endcase
    end

    assign timeout = active & ~(ok | resp_err) & (cnt == TMO_LAST);

endmodule

// File: rtl/gtfmac_cfg_sequencer.sv
// Programs CFG8..CFG12 over AXI-Lite, optionally reads them back and compares.
// Ports: start + cfg_* in; AXI-Lite master; busy/done/error/err_code/err_idx out.
module gtfmac_cfg_sequencer
    import gtfmac_cfg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          NUM_REGS    = 5,
    parameter int          TIMEOUT_CYC = 1024,
    parameter int          VERIFY      = 1
) (
    input  logic        S0_s_axi_aclk,
    input  logic        S0_s_axi_aresetn,
    input  logic        start,
    input  logic        cfg_rx_data_rate,
    input  logic        cfg_tx_data_rate,
    input  logic        cfg_tx_fcs_ins_enable,
    input  logic        cfg_tx_ignore_fcs,
    input  logic        cfg_rx_ignore_fcs,
    input  logic [7:0]  cfg_rx_min_packet_len,
    input  logic [15:0] cfg_rx_max_packet_len,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [2:0]  err_idx
);

    state_t      state, state_n;
    logic [1:0]  code_n;
    logic [2:0]  idx;
    cfg_t        shadow;
    logic        x_ok, x_resp_err, x_tmo;
    logic [31:0] x_rdata, addr, wdata;
    logic        accept, last, mismatch, clr, idx_step;

    assign accept   = (state == ST_IDLE) & start;
    assign last     = (idx == 3'(NUM_REGS - 1));
    assign addr     = BASE_ADDR + reg_offset(idx);
    assign wdata    = table_word(idx, shadow);
    assign mismatch = (x_rdata & field_mask(idx)) != wdata;
    assign clr      = (state_n != state);
    assign idx_step = ((state == ST_WR_RESP) & (state_n == ST_WR))
                    | ((state == ST_RD_DATA) & (state_n == ST_RD));

    gtfmac_axil_single_xact #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_xact (
        .S0_s_axi_aclk   (S0_s_axi_aclk),
        .S0_s_axi_aresetn(S0_s_axi_aresetn),
        .state           (state),
        .clr             (clr),
        .addr            (addr),
        .wdata           (wdata),
        .ok              (x_ok),
        .resp_err        (x_resp_err),
        .timeout         (x_tmo),
        .rdata           (x_rdata),
        .m_axi_awaddr    (m_axi_awaddr),
        .m_axi_awvalid   (m_axi_awvalid),
        .m_axi_awready   (m_axi_awready),
        .m_axi_wdata     (m_axi_wdata),
        .m_axi_wstrb     (m_axi_wstrb),
        .m_axi_wvalid    (m_axi_wvalid),
        .m_axi_wready    (m_axi_wready),
        .m_axi_bresp     (m_axi_bresp),
        .m_axi_bvalid    (m_axi_bvalid),
        .m_axi_bready    (m_axi_bready),
        .m_axi_araddr    (m_axi_araddr),
        .m_axi_arvalid   (m_axi_arvalid),
        .m_axi_arready   (m_axi_arready),
        .m_axi_rdata     (m_axi_rdata),
        .m_axi_rresp     (m_axi_rresp),
        .m_axi_rvalid    (m_axi_rvalid),
        .m_axi_rready    (m_axi_rready)
    );

    always_ff @(posedge S0_s_axi_aclk or negedge S0_s_axi_aresetn) begin
        if (!S0_s_axi_aresetn)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        code_n  = ERR_NONE;
        unique case (state)
            ST_IDLE:
                if (start) state_n = ST_WR;
            ST_WR:
                if (x_ok) state_n = ST_WR_RESP;
                else if (x_tmo) begin
                    state_n = ST_ERR;
                    code_n  = ERR_TIMEOUT;
                end
            ST_WR_RESP:
                if (x_ok) begin
                    if (!last) state_n = ST_WR;
                    else if (VERIFY != 0) state_n = ST_RD;
                    else state_n = ST_DONE;
                end else if (x_resp_err) begin
                    state_n = ST_ERR;
                    code_n  = ERR_RESP;
                end else if (x_tmo) begin
                    state_n = ST_ERR;
                    code_n  = ERR_TIMEOUT;
                end
            ST_RD:
                if (x_ok) state_n = ST_RD_DATA;
                else if (x_tmo) begin
                    state_n = ST_ERR;
                    code_n  = ERR_TIMEOUT;
                end
            ST_RD_DATA:
                if (x_ok && mismatch) begin
                    state_n = ST_ERR;
                    code_n  = ERR_MISMATCH;
                end else if (x_ok) begin
                    state_n = last ? ST_DONE : ST_RD;
                end else if (x_resp_err) begin
                    state_n = ST_ERR;
                    code_n  = ERR_RESP;
                end else if (x_tmo) begin
                    state_n = ST_ERR;
                    code_n  = ERR_TIMEOUT;
                end
            ST_DONE: state_n = ST_IDLE;
            ST_ERR:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    always_ff @(posedge S0_s_axi_aclk or negedge S0_s_axi_aresetn) begin
        if (!S0_s_axi_aresetn) begin
            shadow   <= '0;
            idx      <= 3'd0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
            err_idx  <= 3'd0;
        end else begin
            if (accept) begin
                shadow   <= {cfg_rx_data_rate, cfg_tx_data_rate,
                             cfg_tx_fcs_ins_enable, cfg_tx_ignore_fcs,
                             cfg_rx_ignore_fcs, cfg_rx_min_packet_len,
                             cfg_rx_max_packet_len};
                error    <= 1'b0;
                err_code <= ERR_NONE;
                err_idx  <= 3'd0;
            end else if (state_n == ST_ERR && state != ST_ERR) begin
                error    <= 1'b1;
                err_code <= code_n;
                err_idx  <= idx;
            end
            if (state == ST_IDLE)
                idx <= 3'd0;
            else if (idx_step)
                idx <= idx + 3'd1;
            else if (state == ST_WR_RESP && state_n == ST_RD)
                idx <= 3'd0;
        end
    end

endmodule

// File: doc/gtfmac_cfg_sequencer.md
Name: gtfmac_cfg_sequencer

Overview:
AXI4-Lite master that programs the GTFMAC MAC control registers (CFG8..CFG12, offsets 0x000-0x010) after reset or on request. It then reads each register back and compares it. It drives the slave port of the GTFMAC AXI crossbar, so bring-up needs no software writes. Reports busy/done/error to the link bring-up logic.

Parameters:
BASE_ADDR, 32'h0000_0000, address of CFG8; entry k is written at BASE_ADDR + 4*k
NUM_REGS, 5, number of table entries (fixed map below, k = 0..4)
TIMEOUT_CYC, 1024, maximum cycles per AXI phase before abort
VERIFY, 1, 1 = read-back compare after the write pass

Ports:
S0_s_axi_aclk  in  1  clock
S0_s_axi_aresetn  in  1  reset
start  in  1  pulse; begins a sequence when idle, ignored when busy
cfg_rx_data_rate  in  1  value for CFG8[0]
cfg_tx_data_rate  in  1  value for CFG8[1]
cfg_tx_fcs_ins_enable  in  1  value for CFG9[1]
cfg_tx_ignore_fcs  in  1  value for CFG9[2]
cfg_rx_ignore_fcs  in  1  value for CFG10[2]
cfg_rx_min_packet_len  in  8  value for CFG11[7:0]
cfg_rx_max_packet_len  in  16  value for CFG12[15:0]
m_axi_aw*/w*/b*/ar*/r*  AXI4-Lite master: awaddr 32, awvalid, awready, wdata 32, wstrb 4, wvalid, wready, bresp 2, bvalid, bready, araddr 32, arvalid, arready, rdata 32, rresp 2, rvalid, rready
busy  out  1  sequence in progress
done  out  1  one-cycle pulse on successful completion
error  out  1  sticky; cleared by the next start
err_code  out  2  1 = bad bresp/rresp, 2 = timeout, 3 = read-back mismatch
err_idx  out  3  table index of the first failure

Behaviour:
- Reset: S0_s_axi_aresetn, asynchronous, active-low; clock S0_s_axi_aclk. All valid/ready outputs, busy, done, error, err_code and err_idx reset to 0; addr/data outputs reset to 0; FSM resets to IDLE.
- cfg_* inputs are sampled into a shadow register on the accepted start. The sequence uses the shadow values only.
- Table data (other bits 0): k0 {30'b0, tx_rate, rx_rate}; k1 {29'b0, tx_ignore, fcs_ins, 1'b0}; k2 {29'b0, rx_ignore, 2'b0}; k3 {24'b0, min_len}; k4 {16'b0, max_len}. wstrb is always 4'hF.
- FSM states: IDLE -> WR -> WR_RESP -> (k < NUM_REGS-1 ? WR, k+1 : (VERIFY ? RD : DONE)); RD -> RD_DATA -> (k < NUM_REGS-1 ? RD, k+1 : DONE); any failure -> ERR; DONE and ERR -> IDLE after one cycle.
- WR: awvalid and wvalid rise in the same cycle. Each drops independently in the cycle after its own ready is sampled high. Awaddr and wdata stay stable while valid is high. Leave WR when both phases are accepted, including when accepted in the same cycle or in different cycles.
- WR_RESP: bready = 1. On bvalid, bresp != 2'b00 gives err_code 1.
- RD: arvalid = 1 until arready. RD_DATA: rready = 1. rresp != OKAY gives code 1. Compare rdata against the table word with the unused bits masked; a mismatch gives code 3.
- Timeout counter: 16 bits, cleared on every state entry. When it reaches TIMEOUT_CYC-1 without a handshake, go to ERR with code 2. On entry to ERR all valids drop immediately; any outstanding response is then ignored.
- busy is 1 from the cycle after the accepted start until the IDLE re-entry. done pulses in the DONE state only. err_code and err_idx latch the first failure and hold until the next start.
- start while busy: ignored, no queuing. start while in ERR: ignored; it takes effect in IDLE.
- Reset mid-transaction: all valids drop asynchronously and no retry is made. Downstream must tolerate an abandoned transaction.
- At most one outstanding transaction at any time.

Decomposition:
- Shared package gtfmac_cfg_pkg: register offset constants MAC_CFG8..12 (0x000..0x010); err_code localparams; state enum; per-entry field masks {32'h3, 32'h6, 32'h4, 32'hFF, 32'hFFFF}.
- One sub-module, gtfmac_axil_single_xact: performs one AXI-Lite write or read with its timeout. It reports ok/resp_err/timeout and rdata. The top level holds the table, index counter and sequencing FSM.

Test Plan:
- Default cfg (rate 0/0, fcs_ins 1, ignores 0, min 64, max 9600), slave with 0-wait ready -> writes 0x000=0, 0x004=0x2, 0x008=0, 0x00C=0x40, 0x010=0x2580, then 5 reads; done pulses once; error = 0.
- Slave asserts wready 3 cycles before awready on entry k1 -> single write to 0x004, no duplicate valid after either handshake; sequence completes.
- Slave returns bresp = 2'b10 on k2 -> error = 1, err_code = 1, err_idx = 2, no write to 0x00C issued.
- arready never asserted, TIMEOUT_CYC = 16 -> ERR 16 cycles after arvalid rises, err_code = 2, arvalid low the next cycle.
- Read-back of 0x010 returns 0x2581 -> err_code = 3, err_idx = 4; next start clears error and a clean run pulses done.
- aresetn asserted during WR_RESP of k1 -> all outputs 0 asynchronously; after release, start re-runs from k0.
